w5300_udp_multi_tx: RTL and testbench

W5300_UDP_MULTI_TX -- requirements
Module: w5300_udp_multi_tx

---
 rtl/w5300_udp_multi_tx.sv | 245 ++++++++++++++++++++++++
 tb/tb_w5300_udp_multi_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_udp_multi_tx.sv
// rtl/w5300_udp_multi_tx.sv - round-robin multi-socket UDP transmit sequencer on the W5300 register bus
// Free-size polling before each send is built in when W5300_UDP_TX_FSR_CHECK_EN is defined.
module w5300_udp_multi_tx #(
  parameter int N_SOCK               = 4,
  parameter int TX_BUFFER_ADDR_WIDTH = 12,
  parameter int FSR_POLL_MAX         = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_SOCK-1:0]               tx_req,
  input  logic [32*N_SOCK-1:0]            dest_ip,
  input  logic [16*N_SOCK-1:0]            dest_port,
  input  logic [16*N_SOCK-1:0]            tx_size,
  input  logic [15:0]                     tx_data,
  output logic [TX_BUFFER_ADDR_WIDTH-1:0] tx_buffer_addr,
  output logic [2:0]                      tx_sel,
  output logic [N_SOCK-1:0]               tx_ack,
  output logic [N_SOCK-1:0]               tx_err,
  output logic                            busy,
  input  logic                            op_status,
  input  logic [15:0]                     rd_data,
  output logic [15:0]                     wr_data,
  output logic [11:0]                     caddr
);

  localparam int AW = TX_BUFFER_ADDR_WIDTH;

  typedef enum logic [3:0] {
    IDLE, ARB, RD_FSR_H, RD_FSR_L, CHK, WR_DIP_H, WR_DIP_L, WR_DPORT,
    WR_DATA, WR_SIZE_H, WR_SIZE_L, WR_CMD, DONE
  } state_t;

  state_t            state_q, state_d;
  logic              gap_q, gap_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [31:0]       ip_q, ip_d;
  logic [15:0]       port_q, port_d;
  logic [15:0]       size_q, size_d;
  logic [AW-1:0]     word_q, word_d;
  logic [AW-1:0]     last_q, last_d;
  logic [N_SOCK-1:0] err_q, err_d;

`ifdef W5300_UDP_TX_FSR_CHECK_EN
  localparam int PW = $clog2(FSR_POLL_MAX + 1) + 1;
  logic [PW-1:0] poll_q, poll_d;
  logic          fsr_h_q, fsr_h_d;
  logic [15:0]   fsr_l_q, fsr_l_d;
`else
  logic unused_rd;
  assign unused_rd = ^{rd_data, 32'(FSR_POLL_MAX)};
`endif

  logic              grant_found;
  logic [2:0]        grant_idx;
  logic [N_SOCK-1:0] grant_oh;
  logic [N_SOCK-1:0] sel_oh;
  logic [15:0]       grant_size;
  logic [16:0]       grant_words;
  logic              grant_oversize;
  logic              is_access;
  logic              xfer;
  logic [9:0]        reg_base;
  logic [5:0]        reg_off;
  logic              op_rd;

  // Search starts one past the previous grant so every requester gets a turn.
  always_comb begin : grant_search
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = 3'd0;
    for (int i = 0; i < N_SOCK; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_SOCK) idx = idx - N_SOCK;
      if (!grant_found && tx_req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_oh   = '0;
    for (int i = 0; i < N_SOCK; i++) begin
      grant_oh[i] = (grant_idx == 3'(i));
      sel_oh[i]   = (sel_q == 3'(i));
    end
  end

  assign grant_size     = tx_size[16*grant_idx +: 16];
  assign grant_words    = ({1'b0, grant_size} + 17'd1) >> 1;
  assign grant_oversize = {15'd0, grant_words} > (32'd1 << AW);
  assign reg_base       = 10'h200 + {1'b0, sel_q, 6'h00};
  assign is_access      = state_q inside {RD_FSR_H, RD_FSR_L, WR_DIP_H, WR_DIP_L, WR_DPORT,
                                          WR_DATA, WR_SIZE_H, WR_SIZE_L, WR_CMD};
  assign xfer           = is_access && !gap_q && op_status;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gap_q   <= 1'b1;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      ip_q    <= '0;
      port_q  <= '0;
      size_q  <= '0;
      word_q  <= '0;
      last_q  <= '0;
      err_q   <= '0;
`ifdef W5300_UDP_TX_FSR_CHECK_EN
      poll_q  <= '0;
      fsr_h_q <= 1'b0;
      fsr_l_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      ip_q    <= ip_d;
      port_q  <= port_d;
      size_q  <= size_d;
      word_q  <= word_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef W5300_UDP_TX_FSR_CHECK_EN
      poll_q  <= poll_d;
      fsr_h_q <= fsr_h_d;
      fsr_l_q <= fsr_l_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    ip_d    = ip_q;
    port_d  = port_q;
    size_d  = size_q;
    word_d  = word_q;
    last_d  = last_q;
    err_d   = err_q;
`ifdef W5300_UDP_TX_FSR_CHECK_EN
    poll_d  = poll_q;
    fsr_h_d = fsr_h_q;
    fsr_l_d = fsr_l_q;
`endif
    // Chip select stays released for one cycle after every completed access.
    gap_d = is_access ? (!gap_q && op_status) : 1'b1;

    case (state_q)
      IDLE: if (|tx_req) state_d = ARB;
      ARB: begin
        if (!grant_found) begin
          state_d = IDLE;
        end else begin
          sel_d  = grant_idx;
          ptr_d  = (grant_idx == 3'(N_SOCK - 1)) ? 3'd0 : grant_idx + 3'd1;
          ip_d   = dest_ip[32*grant_idx +: 32];
          port_d = dest_port[16*grant_idx +: 16];
          size_d = grant_size;
          word_d = '0;
          last_d = AW'(grant_words - 17'd1);
`ifdef W5300_UDP_TX_FSR_CHECK_EN
          poll_d = '0;
`endif
          if (grant_size == 16'd0) begin
            state_d = DONE;
          end else if (grant_oversize) begin
            err_d   = err_q | grant_oh;
            state_d = DONE;
          end else begin
`ifdef W5300_UDP_TX_FSR_CHECK_EN
            state_d = RD_FSR_H;
`else
            state_d = WR_DIP_H;
`endif
          end
        end
      end
`ifdef W5300_UDP_TX_FSR_CHECK_EN
      RD_FSR_H: if (xfer) begin
        fsr_h_d = rd_data[0];
        state_d = RD_FSR_L;
      end
      RD_FSR_L: if (xfer) begin
        fsr_l_d = rd_data;
        state_d = CHK;
      end
      CHK: begin
        if ({fsr_h_q, fsr_l_q} >= {1'b0, size_q}) begin
          state_d = WR_DIP_H;
        end else if (poll_q == PW'(FSR_POLL_MAX)) begin
          err_d   = err_q | sel_oh;
          state_d = DONE;
        end else begin
          poll_d  = poll_q + PW'(1);
          state_d = RD_FSR_H;
        end
      end
`endif
      WR_DIP_H:  if (xfer) state_d = WR_DIP_L;
      WR_DIP_L:  if (xfer) state_d = WR_DPORT;
      WR_DPORT:  if (xfer) state_d = WR_DATA;
      WR_DATA: if (xfer) begin
        if (word_q == last_q) state_d = WR_SIZE_H;
        else                  word_d  = word_q + AW'(1);
      end
      WR_SIZE_H: if (xfer) state_d = WR_SIZE_L;
      WR_SIZE_L: if (xfer) state_d = WR_CMD;
      WR_CMD:    if (xfer) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    op_rd   = 1'b0;
    reg_off = 6'h00;
    wr_data = 16'h0000;
    case (state_q)
      RD_FSR_H:  begin op_rd = 1'b1; reg_off = 6'h24; end
      RD_FSR_L:  begin op_rd = 1'b1; reg_off = 6'h26; end
      WR_DIP_H:  begin reg_off = 6'h14; wr_data = ip_q[31:16]; end
      WR_DIP_L:  begin reg_off = 6'h16; wr_data = ip_q[15:0]; end
      WR_DPORT:  begin reg_off = 6'h12; wr_data = port_q; end
      WR_DATA:   begin reg_off = 6'h2E; wr_data = tx_data; end
      WR_SIZE_H: begin reg_off = 6'h20; wr_data = 16'h0000; end
      WR_SIZE_L: begin reg_off = 6'h22; wr_data = size_q; end
      WR_CMD:    begin reg_off = 6'h02; wr_data = 16'h0020; end
      default:   begin op_rd = 1'b0; end
    endcase
    caddr  = is_access ? {gap_q, op_rd, reg_base + {4'd0, reg_off}} : 12'hC00;
    tx_ack = (state_q == DONE) ? sel_oh : '0;
  end

  assign tx_sel         = sel_q;
  assign tx_err         = err_q;
  assign busy           = (state_q != IDLE);
  assign tx_buffer_addr = word_q;

endmodule

// File: tb/tb_w5300_udp_multi_tx.sv
// tb/tb_w5300_udp_multi_tx.sv - directed self-checking bench for w5300_udp_multi_tx
`timescale 1ns/1ps
module tb_w5300_udp_multi_tx;
  localparam int NS = 4;
  localparam int AW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NS-1:0]  tx_req = '0;
  logic [32*NS-1:0] dest_ip = '0;
  logic [16*NS-1:0] dest_port = '0;
  logic [16*NS-1:0] tx_size = '0;
  logic [15:0]    tx_data = '0;
  logic [AW-1:0]  tx_buffer_addr;
  logic [2:0]     tx_sel;
  logic [NS-1:0]  tx_ack;
  logic [NS-1:0]  tx_err;
  logic           busy;
  logic           op_status = 1'b0;
  logic [15:0]    rd_data = '0;
  logic [15:0]    wr_data;
  logic [11:0]    caddr;

  w5300_udp_multi_tx #(.N_SOCK(NS), .TX_BUFFER_ADDR_WIDTH(AW), .FSR_POLL_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .dest_ip(dest_ip), .dest_port(dest_port),
    .tx_size(tx_size), .tx_data(tx_data), .tx_buffer_addr(tx_buffer_addr), .tx_sel(tx_sel),
    .tx_ack(tx_ack), .tx_err(tx_err), .busy(busy), .op_status(op_status), .rd_data(rd_data),
    .wr_data(wr_data), .caddr(caddr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [26:0] log_q[$];
  logic [26:0] exp_q[$];
  logic [AW-1:0] buf_q[$];
  int ack_order[$];
  int sel_at_ack[$];
  int ack_cycles[NS];
  int cs_low_cnt = 0;
  int wait_cnt = 0;
  logic [16:0] fsr = 17'h10000;

  // Bus slave: completes each access on its second chip-select-low cycle; buffer has half-cycle latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      op_status = 1'b0;
      wait_cnt  = 0;
    end else begin
      tx_data = 16'hD000 + {12'd0, tx_buffer_addr};
      rd_data = (caddr[5:0] == 6'h24) ? {15'd0, fsr[16]} : fsr[15:0];
      if (caddr[11] == 1'b0) cs_low_cnt++;
      if (caddr[11] == 1'b0 && !op_status) begin
        if (wait_cnt == 1) begin
          op_status = 1'b1;
          wait_cnt  = 0;
          log_q.push_back({caddr[10], caddr[9:0], caddr[10] ? rd_data : wr_data});
          if (!caddr[10] && caddr[5:0] == 6'h2E) buf_q.push_back(tx_buffer_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        op_status = 1'b0;
      end
      for (int s = 0; s < NS; s++) begin
        if (tx_ack[s]) begin
          ack_cycles[s]++;
          ack_order.push_back(s);
          sel_at_ack.push_back(int'(tx_sel));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] ent(input logic op, input logic [9:0] a, input logic [15:0] d);
    return {op, a, d};
  endfunction

  task automatic clear_logs();
    log_q.delete();
    buf_q.delete();
    ack_order.delete();
    sel_at_ack.delete();
    for (int s = 0; s < NS; s++) ack_cycles[s] = 0;
    cs_low_cnt = 0;
  endtask

  task automatic check_log(input string tag);
    logic [31:0] obs;
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < log_q.size()) obs = {5'd0, log_q[i]};
      chk($sformatf("%s[%0d]", tag, i), obs, {5'd0, exp_q[i]});
    end
  endtask

  task automatic set_sock(input int s, input logic [31:0] ip, input logic [15:0] port,
                          input logic [15:0] size);
    dest_ip[s*32 +: 32]   = ip;
    dest_port[s*16 +: 16] = port;
    tx_size[s*16 +: 16]   = size;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input int s, input int limit, output int cycles);
    cycles = -1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      #1;
      if (tx_ack[s]) begin
        cycles = n;
        tx_req[s] = 1'b0;
        break;
      end
    end
    if (cycles < 0) tx_req[s] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic push_sock0_size5();
    exp_q.delete();
`ifdef W5300_UDP_TX_FSR_CHECK_EN
    exp_q.push_back(ent(1'b1, 10'h224, 16'h0001));
    exp_q.push_back(ent(1'b1, 10'h226, 16'h0000));
`endif
    exp_q.push_back(ent(1'b0, 10'h214, 16'hC0A8));
    exp_q.push_back(ent(1'b0, 10'h216, 16'h0164));
    exp_q.push_back(ent(1'b0, 10'h212, 16'h1F90));
    exp_q.push_back(ent(1'b0, 10'h22E, 16'hD000));
    exp_q.push_back(ent(1'b0, 10'h22E, 16'hD001));
    exp_q.push_back(ent(1'b0, 10'h22E, 16'hD002));
    exp_q.push_back(ent(1'b0, 10'h220, 16'h0000));
    exp_q.push_back(ent(1'b0, 10'h222, 16'h0005));
    exp_q.push_back(ent(1'b0, 10'h202, 16'h0020));
  endtask

  initial begin
    int cyc;
    int hdr;
    logic [9:0] dip[$];

`ifdef W5300_UDP_TX_FSR_CHECK_EN
    hdr = 2;
`else
    hdr = 0;
`endif
    tick(3);
    chk("rst_caddr", 32'(caddr), 32'hC00);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_buf_addr", 32'(tx_buffer_addr), 32'h0);
    chk("rst_tx_sel", 32'(tx_sel), 32'h0);
    chk("rst_tx_ack", 32'(tx_ack), 32'h0);
    chk("rst_tx_err", 32'(tx_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Basic socket 0 send: 5 bytes -> 3 buffer words.
    set_sock(0, 32'hC0A8_0164, 16'h1F90, 16'd5);
    clear_logs();
    push_sock0_size5();
    tx_req[0] = 1'b1;
    wait_ack(0, 500, cyc);
    chk("s0_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("s0_ack_width", 32'(ack_cycles[0]), 32'd1);
    check_log("s0_seq");
    chk("s0_buf_len", 32'(buf_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("s0_buf[%0d]", i), (i < buf_q.size()) ? 32'(buf_q[i]) : 32'hFFFF_FFFF, 32'(i));
    chk("s0_err", 32'(tx_err), 32'h0);
    chk("s0_busy_after", 32'(busy), 32'h0);

    // Round robin from reset with 1011 held.
    pulse_reset();
    set_sock(0, 32'h0A00_0000, 16'h0100, 16'd2);
    set_sock(1, 32'h0A00_0001, 16'h0101, 16'd2);
    set_sock(3, 32'h0A00_0003, 16'h0103, 16'd2);
    clear_logs();
    tx_req = 4'b1011;
    for (int n = 0; n < 2000; n++) begin
      tick(1);
      if (ack_order.size() >= 4) break;
    end
    tx_req = 4'b0000;
    tick(3);
    chk("rr_ack_count", 32'(ack_order.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      int expect_s;
      expect_s = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 0;
      chk($sformatf("rr_grant[%0d]", i), (i < ack_order.size()) ? 32'(ack_order[i]) : 32'hFFFF_FFFF,
          32'(expect_s));
      chk($sformatf("rr_sel[%0d]", i), (i < sel_at_ack.size()) ? 32'(sel_at_ack[i]) : 32'hFFFF_FFFF,
          32'(expect_s));
    end
    foreach (log_q[i]) if (!log_q[i][26] && log_q[i][21:16] == 6'h14) dip.push_back(log_q[i][25:16]);
    chk("rr_dip_count", 32'(dip.size()), 32'd4);
    chk("rr_base0", (dip.size() > 0) ? 32'(dip[0]) : 32'hFFFF_FFFF, 32'h214);
    chk("rr_base1", (dip.size() > 1) ? 32'(dip[1]) : 32'hFFFF_FFFF, 32'h254);
    chk("rr_base2", (dip.size() > 2) ? 32'(dip[2]) : 32'hFFFF_FFFF, 32'h2D4);
    chk("rr_base3", (dip.size() > 3) ? 32'(dip[3]) : 32'hFFFF_FFFF, 32'h214);

    // Zero-length request completes without any bus access.
    set_sock(1, 32'h0A00_0011, 16'h0111, 16'd0);
    clear_logs();
    tx_req[1] = 1'b1;
    wait_ack(1, 3, cyc);
    chk("zero_ack_in_3", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("zero_no_cs", 32'(cs_low_cnt), 32'd0);
    chk("zero_err", 32'(tx_err), 32'h0);

    // Largest buffer-fitting size (16 words); request withdrawn mid-transfer.
    set_sock(2, 32'h0A00_0002, 16'h1234, 16'd32);
    clear_logs();
    tx_req[2] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      tick(1);
      if (log_q.size() >= 1) break;
    end
    tx_req[2] = 1'b0;
    wait_ack(2, 1000, cyc);
    chk("max_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("max_log_len", 32'(log_q.size()), 32'(hdr + 22));
    chk("max_buf_len", 32'(buf_q.size()), 32'd16);
    chk("max_last_buf", (buf_q.size() > 0) ? 32'(buf_q[buf_q.size()-1]) : 32'hFFFF_FFFF, 32'd15);
    chk("max_last_data", (log_q.size() > hdr + 18) ? 32'(log_q[hdr+18]) : 32'hFFFF_FFFF,
        32'(ent(1'b0, 10'h2AE, 16'hD00F)));
    chk("max_cmd", (log_q.size() > 0) ? 32'(log_q[log_q.size()-1]) : 32'hFFFF_FFFF,
        32'(ent(1'b0, 10'h282, 16'h0020)));
    chk("max_err", 32'(tx_err), 32'h0);

    // One word past the buffer: error, no access.
    set_sock(2, 32'h0A00_0002, 16'h1234, 16'd33);
    clear_logs();
    tx_req[2] = 1'b1;
    wait_ack(2, 10, cyc);
    chk("over_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("over_no_cs", 32'(cs_low_cnt), 32'd0);
    chk("over_err", 32'(tx_err), 32'h4);

    // 1-byte send rounds up to one word; error flag stays sticky.
    set_sock(3, 32'h0A00_0003, 16'h0103, 16'd1);
    clear_logs();
    tx_req[3] = 1'b1;
    wait_ack(3, 500, cyc);
    chk("one_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("one_buf_len", 32'(buf_q.size()), 32'd1);
    chk("one_size_l", (log_q.size() > hdr + 5) ? 32'(log_q[hdr+5]) : 32'hFFFF_FFFF,
        32'(ent(1'b0, 10'h2E2, 16'h0001)));
    chk("one_err_sticky", 32'(tx_err), 32'h4);

`ifdef W5300_UDP_TX_FSR_CHECK_EN
    // Free size never sufficient: initial read pair plus three re-polls, then drop.
    pulse_reset();
    fsr = 17'd40;
    set_sock(2, 32'h0A00_0002, 16'h1234, 16'd100);
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ent(1'b1, 10'h2A4, 16'h0000));
      exp_q.push_back(ent(1'b1, 10'h2A6, 16'h0028));
    end
    tx_req[2] = 1'b1;
    wait_ack(2, 500, cyc);
    chk("fsr_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    check_log("fsr_poll");
    chk("fsr_ack_width", 32'(ack_cycles[2]), 32'd1);
    chk("fsr_err", 32'(tx_err), 32'h4);
    fsr = 17'h10000;
`endif

    // Reset during the second data word, then a fresh send.
    set_sock(0, 32'hC0A8_0164, 16'h1F90, 16'd5);
    clear_logs();
    tx_req[0] = 1'b1;
    cyc = -1;
    for (int n = 0; n < 500; n++) begin
      tick(1);
      if (caddr[11] == 1'b0 && caddr[9:0] == 10'h22E && tx_buffer_addr == 4'd1) begin
        cyc = n;
        break;
      end
    end
    chk("mid_reached", 32'(cyc >= 0), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_caddr", 32'(caddr), 32'hC00);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_buf_addr", 32'(tx_buffer_addr), 32'h0);
    chk("mid_wr_data", 32'(wr_data), 32'h0);
    chk("mid_err", 32'(tx_err), 32'h0);
    tx_req[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_busy", 32'(busy), 32'h0);
    clear_logs();
    push_sock0_size5();
    tx_req[0] = 1'b1;
    wait_ack(0, 500, cyc);
    chk("post_ack_seen", 32'(cyc > 0), 32'h1);
    tick(2);
    chk("post_first", (log_q.size() > 0) ? 32'(log_q[0]) : 32'hFFFF_FFFF, 32'(exp_q[0]));
    check_log("post_seq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
